// File: rtl/instr_encoder.sv
// Encodes LEGv8-style instruction requests into 32-bit words and writes them
// sequentially into an instruction memory through a ready/valid write port.
module instr_encoder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rn,
  input  logic [4:0]            rm,
  input  logic [25:0]           imm,
  output logic                  mem_wr_en,
  input  logic                  mem_wr_ready,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  full,
  output logic                  err,
  output logic [DEPTH_LOG2:0]   words_written
);

  logic                  live_reg;
  logic                  wr_en_reg;
  logic [31:0]           data_reg;
  logic [DEPTH_LOG2-1:0] addr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  full_reg;
  logic                  err_reg;

  logic [31:0] word_next;
  logic        reject;
  logic        accept;
  logic        write_done;

  // A signed immediate fits in N bits when every bit from N-1 upward agrees.
  always_comb begin
    word_next = '0;
    reject    = 1'b0;
    case (op)
      4'd0:  word_next = 32'h8B00_0000 | {11'b0, rm, 6'b0, rn, rd};
      4'd1:  word_next = 32'hCB00_0000 | {11'b0, rm, 6'b0, rn, rd};
      4'd2:  word_next = 32'h8A00_0000 | {11'b0, rm, 6'b0, rn, rd};
      4'd3:  word_next = 32'hAA00_0000 | {11'b0, rm, 6'b0, rn, rd};
      4'd4:  word_next = 32'hEA00_0000 | {11'b0, rm, 6'b0, rn, rd};
      4'd5:  word_next = 32'h9100_0000 | {10'b0, imm[11:0], rn, rd};
      4'd6:  word_next = 32'hD100_0000 | {10'b0, imm[11:0], rn, rd};
      4'd7:  word_next = 32'h9200_0000 | {10'b0, imm[11:0], rn, rd};
      4'd8:  word_next = 32'hB200_0000 | {10'b0, imm[11:0], rn, rd};
      4'd9:  word_next = 32'hD200_0000 | {10'b0, imm[11:0], rn, rd};
      4'd10: word_next = 32'hF840_0000 | {11'b0, imm[8:0], 2'b0, rn, rd};
      4'd11: word_next = 32'hF800_0000 | {11'b0, imm[8:0], 2'b0, rn, rd};
      4'd12: word_next = 32'hB400_0000 | {8'b0, imm[18:0], rd};
      4'd13: word_next = 32'hB500_0000 | {8'b0, imm[18:0], rd};
      4'd14: word_next = 32'h1400_0000 | {6'b0, imm};
      default: word_next = 32'hD280_0000 | {11'b0, rm, 11'b0, rd};
    endcase
    if (op >= 4'd5 && op <= 4'd9) begin
      reject = |imm[25:12];
    end else if (op == 4'd10 || op == 4'd11) begin
      reject = !((&imm[25:8]) || !(|imm[25:8]));
    end else if (op == 4'd12 || op == 4'd13) begin
      reject = !((&imm[25:18]) || !(|imm[25:18]));
    end
  end

  assign in_ready   = live_reg && !full_reg && !clear && (!wr_en_reg || mem_wr_ready);
  assign accept     = in_valid && in_ready;
  assign write_done = wr_en_reg && mem_wr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_reg  <= 1'b0;
      wr_en_reg <= 1'b0;
      data_reg  <= '0;
      addr_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (clear) begin
        wr_en_reg <= 1'b0;
        data_reg  <= '0;
        addr_reg  <= '0;
        count_reg <= '0;
        full_reg  <= 1'b0;
        err_reg   <= 1'b0;
      end else begin
        // Address advances on completion; a word accepted on the same edge
        // therefore lands at the incremented (possibly wrapped) address.
        if (write_done) begin
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_reg + 1'b1;
          if (addr_reg == '1) begin
            full_reg <= 1'b1;
          end
        end
        if (accept && !reject) begin
          wr_en_reg <= 1'b1;
          data_reg  <= word_next;
        end else if (write_done) begin
          wr_en_reg <= 1'b0;
          data_reg  <= '0;
        end
        if (accept && reject) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_wr_en     = wr_en_reg;
  assign mem_wr_data   = data_reg;
  assign mem_addr      = addr_reg;
  assign full          = full_reg;
  assign err           = err_reg;
  assign words_written = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// handshake/clear/reset sequences, and randomized traffic against a model.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        mem_wr_ready = 1'b1;
  logic [3:0]  op = '0;
  logic [4:0]  rd = '0, rn = '0, rm = '0;
  logic [25:0] imm = '0;

  logic        in_ready, mem_wr_en, full, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [8:0]  words_written;

  logic        s_in_ready, s_mem_wr_en, s_full, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wr_data;
  logic [2:0]  s_words_written;

  instr_encoder #(.DEPTH_LOG2(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .full(full), .err(err), .words_written(words_written)
  );

  instr_encoder #(.DEPTH_LOG2(2)) u_small (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(s_in_ready), .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .mem_wr_en(s_mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_addr(s_mem_addr),
    .mem_wr_data(s_mem_wr_data), .full(s_full), .err(s_err), .words_written(s_words_written)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic        rej;
    logic [31:0] word;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[18];
  wr_t  exp_q[$];

  longint bases[16] = '{64'h8B000000, 64'hCB000000, 64'h8A000000, 64'hAA000000,
                        64'hEA000000, 64'h91000000, 64'hD1000000, 64'h92000000,
                        64'hB2000000, 64'hD2000000, 64'hF8400000, 64'hF8000000,
                        64'hB4000000, 64'hB5000000, 64'h14000000, 64'hD2800000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: field values placed by arithmetic weight, ranges by signed value.
  function automatic void ref_encode(input logic [3:0] o, input logic [4:0] d, n, m,
                                     input logic [25:0] im, output logic rej,
                                     output logic [31:0] w);
    longint acc, s, ld, ln, lm;
    s   = longint'($signed(im));
    ld  = longint'(d);
    ln  = longint'(n);
    lm  = longint'(m);
    acc = bases[o];
    rej = 1'b0;
    if (o <= 4) begin
      acc += lm * 65536 + ln * 32 + ld;
    end else if (o <= 9) begin
      rej = (longint'(im) > 4095);
      acc += (longint'(im) % 4096) * 1024 + ln * 32 + ld;
    end else if (o <= 11) begin
      rej = (s < -256) || (s > 255);
      acc += (((s % 512) + 512) % 512) * 4096 + ln * 32 + ld;
    end else if (o <= 13) begin
      rej = (s < -262144) || (s > 262143);
      acc += (((s % 524288) + 524288) % 524288) * 32 + ld;
    end else if (o == 14) begin
      acc += longint'(im);
    end else begin
      acc += lm * 65536 + ld;
    end
    w = acc[31:0];
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [4:0] d, n, m, input logic [25:0] im);
    int waited = 0;
    op = o; rd = d; rn = n; rm = m; imm = im;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_err;
    logic [7:0]  exp_addr;
    logic        rrej;
    logic [31:0] rword;
    logic [7:0]  acc_addr;
    int          n_written;

    vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  26'd10,       1'b0, 32'h8B030041};
    vecs[1]  = '{4'd5,  5'd5,  5'd5,  5'd0,  26'd10,       1'b0, 32'h910028A5};
    vecs[2]  = '{4'd13, 5'd9,  5'd0,  5'd0,  26'h3FFFFFE,  1'b0, 32'hB5FFFFC9};
    vecs[3]  = '{4'd10, 5'd1,  5'd2,  5'd0,  26'd256,      1'b1, 32'h0};
    vecs[4]  = '{4'd11, 5'd1,  5'd2,  5'd0,  26'h3FFFFFF,  1'b0, 32'hF81FF041};
    vecs[5]  = '{4'd7,  5'd31, 5'd0,  5'd0,  26'd4095,     1'b0, 32'h923FFC1F};
    vecs[6]  = '{4'd7,  5'd31, 5'd0,  5'd0,  26'd4096,     1'b1, 32'h0};
    vecs[7]  = '{4'd10, 5'd0,  5'd31, 5'd0,  26'h3FFFF00,  1'b0, 32'hF85003E0};
    vecs[8]  = '{4'd10, 5'd0,  5'd31, 5'd0,  26'h3FFFEFF,  1'b1, 32'h0};
    vecs[9]  = '{4'd12, 5'd3,  5'd0,  5'd0,  26'h003FFFF,  1'b0, 32'hB47FFFE3};
    vecs[10] = '{4'd12, 5'd0,  5'd0,  5'd0,  26'h3FC0000,  1'b0, 32'hB4800000};
    vecs[11] = '{4'd12, 5'd0,  5'd0,  5'd0,  26'h0040000,  1'b1, 32'h0};
    vecs[12] = '{4'd14, 5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  1'b0, 32'h17FFFFFF};
    vecs[13] = '{4'd15, 5'd7,  5'd31, 5'd20, 26'd0,        1'b0, 32'hD2940007};
    vecs[14] = '{4'd4,  5'd2,  5'd3,  5'd31, 26'd0,        1'b0, 32'hEA1F0062};
    vecs[15] = '{4'd6,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  1'b1, 32'h0};
    vecs[16] = '{4'd11, 5'd1,  5'd1,  5'd0,  26'd255,      1'b0, 32'hF80FF021};
    vecs[17] = '{4'd8,  5'd1,  5'd2,  5'd0,  26'h800,      1'b0, 32'hB2200041};

    // Reset state, asynchronous
    #1;
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_words", words_written, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1 check("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clock);
    #1 check("rel_in_ready_after_edge", in_ready, 1);

    // Directed vector table
    exp_err  = 1'b0;
    exp_addr = 8'd0;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      @(negedge clock);
      $display("vec %0d op=%0d imm=0x%0h wr_en=%0d addr=%0d data=0x%08h err=%0d",
               i, vecs[i].op, vecs[i].imm, mem_wr_en, mem_addr, mem_wr_data, err);
      if (vecs[i].rej) begin
        exp_err = 1'b1;
        check("vec_rej_wr_en", mem_wr_en, 0);
        check("vec_rej_addr", mem_addr, exp_addr);
      end else begin
        check("vec_wr_en", mem_wr_en, 1);
        check("vec_addr", mem_addr, exp_addr);
        check("vec_data", mem_wr_data, vecs[i].word);
        exp_addr++;
      end
      check("vec_err", err, exp_err);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("vec_words", words_written, exp_addr);
    @(posedge clock);
    #1;

    // Back-to-back writes at 1/cycle
    do_clear();
    op = 4'd5; rd = 5'd5; rn = 5'd5; rm = 5'd0; imm = 26'd10; in_valid = 1'b1;
    @(posedge clock);
    #1 op = 4'd13; rd = 5'd9; rn = 5'd0; imm = 26'h3FFFFFE;
    @(negedge clock);
    check("b2b_first_en", mem_wr_en, 1);
    check("b2b_first_addr", mem_addr, 0);
    check("b2b_first_data", mem_wr_data, 32'h910028A5);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("b2b_second_en", mem_wr_en, 1);
    check("b2b_second_addr", mem_addr, 1);
    check("b2b_second_data", mem_wr_data, 32'hB5FFFFC9);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("b2b_idle_en", mem_wr_en, 0);
    check("b2b_idle_data", mem_wr_data, 0);
    check("b2b_words", words_written, 2);
    $display("seq back_to_back words=%0d", words_written);
    @(posedge clock);
    #1;

    // Stalled write holds for three edges, completes on the fourth
    do_clear();
    mem_wr_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_en", mem_wr_en, 1);
      check("stall_addr", mem_addr, 0);
      check("stall_data", mem_wr_data, 32'h8B030041);
      check("stall_in_ready", in_ready, 0);
      @(posedge clock);
      #1;
    end
    mem_wr_ready = 1'b1;
    @(negedge clock);
    check("stall_release_in_ready", in_ready, 1);
    check("stall_release_words", words_written, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("stall_done_en", mem_wr_en, 0);
    check("stall_done_words", words_written, 1);
    check("stall_done_addr", mem_addr, 1);
    $display("seq stall words=%0d addr=%0d", words_written, mem_addr);

    // Reset during a pending write
    @(posedge clock);
    #1 mem_wr_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    @(negedge clock);
    check("rstw_pending", mem_wr_en, 1);
    reset_n = 1'b0;
    #1;
    check("rstw_en", mem_wr_en, 0);
    check("rstw_data", mem_wr_data, 0);
    check("rstw_addr", mem_addr, 0);
    check("rstw_words", words_written, 0);
    check("rstw_in_ready", in_ready, 0);
    mem_wr_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 check("rstw_words_after", words_written, 0);
    send(4'd5, 5'd5, 5'd5, 5'd0, 26'd10);
    @(negedge clock);
    check("rstw_next_addr", mem_addr, 0);
    check("rstw_next_data", mem_wr_data, 32'h910028A5);
    $display("seq reset_abort addr=%0d data=0x%08h", mem_addr, mem_wr_data);
    @(posedge clock);
    #1;

    // Clear drops a pending write and ignores in_valid on that edge
    mem_wr_ready = 1'b0;
    send(4'd1, 5'd4, 5'd5, 5'd6, 26'd0);
    clear = 1'b1;
    op = 4'd0; in_valid = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0; in_valid = 1'b0; mem_wr_ready = 1'b1;
    @(negedge clock);
    check("clr_en", mem_wr_en, 0);
    check("clr_data", mem_wr_data, 0);
    check("clr_addr", mem_addr, 0);
    check("clr_words", words_written, 0);
    $display("seq clear_drop wr_en=%0d", mem_wr_en);
    @(posedge clock);
    #1;

    // Small instance: fill four words, refuse a fifth, then clear
    do_clear();
    send(4'd10, 5'd1, 5'd2, 5'd0, 26'd256);
    for (int k = 0; k < 4; k++) send(4'd0, 5'(k), 5'd0, 5'd0, 26'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("full_flag", s_full, 1);
    check("full_in_ready", s_in_ready, 0);
    check("full_words", s_words_written, 4);
    check("full_addr_wrap", s_mem_addr, 0);
    check("full_err", s_err, 1);
    check("big_not_full", full, 0);
    check("big_words", words_written, 4);
    @(posedge clock);
    #1 op = 4'd0; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("full_fifth_en", s_mem_wr_en, 0);
    check("full_fifth_words", s_words_written, 4);
    $display("seq full words=%0d full=%0d", s_words_written, s_full);
    @(posedge clock);
    #1 do_clear();
    @(negedge clock);
    check("full_clr_full", s_full, 0);
    check("full_clr_addr", s_mem_addr, 0);
    check("full_clr_err", s_err, 0);
    check("full_clr_in_ready", s_in_ready, 1);
    check("full_clr_words", s_words_written, 0);
    @(posedge clock);
    #1;

    // Randomized traffic against the reference model
    do_clear();
    exp_err   = 1'b0;
    acc_addr  = 8'd0;
    n_written = 0;
    exp_q.delete();
    for (int c = 0; c < 420; c++) begin
      in_valid     = (c < 360) && ($urandom_range(0, 4) < 3);
      mem_wr_ready = (c >= 360) || ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      rd = 5'($urandom_range(0, 31));
      rn = 5'($urandom_range(0, 31));
      rm = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: imm = 26'($urandom_range(0, 600)) - 26'd300;
        1: imm = 26'($urandom_range(0, 8191));
        2: imm = 26'($urandom);
        3: imm = 26'($urandom_range(0, 8)) + 26'h003FFFC;
        default: imm = 26'h3FC0000 + 26'($urandom_range(0, 8)) - 26'd4;
      endcase
      @(negedge clock);
      check("rnd_wr_en", mem_wr_en, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rnd_addr", mem_addr, exp_q[0].addr);
        check("rnd_data", mem_wr_data, exp_q[0].data);
        if (!mem_wr_ready) check("rnd_stall_in_ready", in_ready, 0);
      end else begin
        check("rnd_idle_data", mem_wr_data, 0);
        check("rnd_idle_in_ready", in_ready, 1);
      end
      check("rnd_err", err, exp_err);
      if (mem_wr_en && mem_wr_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_written++;
      end
      if (in_valid && in_ready) begin
        ref_encode(op, rd, rn, rm, imm, rrej, rword);
        if (rrej) begin
          exp_err = 1'b1;
        end else begin
          exp_q.push_back('{addr: acc_addr, data: rword});
          acc_addr++;
        end
      end
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_words", words_written, n_written);
    $display("seq random words=%0d err=%0d", words_written, err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter: DEPTH_LOG2, default 8, log2 of instruction-memory words written.
REQ-002 SHALL have ports, one per line:
  clock  in  1  single clock; all state changes on its rising edge.
  reset_n  in  1  reset, asynchronous and active-low.
  clear  in  1  synchronous restart of the write sequence.
  in_valid  in  1  source presents an instruction request.
  in_ready  out  1  encoder accepts a request this cycle.
  op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 ADDI, 6 SUBI, 7 ANDI, 8 ORRI, 9 EORI, 10 LDUR, 11 STUR, 12 CBZ, 13 CBNZ, 14 B, 15 MOV.
  rd  in  5  destination register, or Rt for LDUR/STUR/CBZ/CBNZ.
  rn  in  5  first source register.
  rm  in  5  second source register; MOV source.
  imm  in  26  two's-complement immediate or offset.
  mem_wr_en  out  1  write request to instruction memory.
  mem_wr_ready  in  1  memory accepts the write this cycle.
  mem_addr  out  DEPTH_LOG2  word address of the pending write.
  mem_wr_data  out  32  encoded instruction word.
  full  out  1  all 2^DEPTH_LOG2 words written.
  err  out  1  sticky flag: a request was rejected for an immediate out of range.
  words_written  out  DEPTH_LOG2+1  count of completed writes.

Function
REQ-003 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-004 SHALL drive in_ready = !full && !clear && (!mem_wr_en || mem_wr_ready).
REQ-005 SHALL register the encoded word for an accepted request and assert mem_wr_en in the following cycle. Latency is 1 cycle, and throughput is 1 per cycle while mem_wr_ready=1.
REQ-006 SHALL hold mem_wr_en, mem_addr and mem_wr_data stable until the write completes. A write completes on an edge where mem_wr_en && mem_wr_ready.
REQ-007 SHALL use these base words: ADD 0x8B000000, SUB 0xCB000000, AND 0x8A000000, ORR 0xAA000000, EOR 0xEA000000, ADDI 0x91000000, SUBI 0xD1000000, ANDI 0x92000000, ORRI 0xB2000000, EORI 0xD2000000, LDUR 0xF8400000, STUR 0xF8000000, CBZ 0xB4000000, CBNZ 0xB5000000, B 0x14000000, MOV 0xD2800000.
REQ-008 SHALL OR the fields into the base word by format:
  R (ops 0-4): rm[20:16], shamt[15:10]=0, rn[9:5], rd[4:0].
  I (ops 5-9): imm[11:0] into [21:10], rn[9:5], rd[4:0].
  D (ops 10-11): imm[8:0] into [20:12], [11:10]=0, rn[9:5], rd[4:0].
  CB (ops 12-13): imm[18:0] into [23:5], rd[4:0].
  B (op 14): imm[25:0] into [25:0].
  MOV (op 15): rm[20:16], rd[4:0], all other field bits 0.
REQ-009 SHALL reject a request whose immediate is out of range:
  I: imm[25:12] not all 0 (valid range 0..4095).
  D: signed value outside -256..255.
  CB: signed value outside -2^18..2^18-1.
  B: never rejected.
REQ-010 A rejected request SHALL still complete its handshake, SHALL cause no write, SHALL leave mem_addr unchanged, and SHALL set err.
REQ-011 SHALL increment mem_addr and words_written on each completed write.
REQ-012 SHALL assert full when the write to address 2^DEPTH_LOG2-1 completes. mem_addr then wraps to 0, and no further requests are accepted until clear or reset.
REQ-013 SHALL honour clear over all other activity when it is high at an edge:
  a pending write is dropped and mem_wr_en goes 0;
  mem_addr, words_written, full and err go to 0;
  in_valid is ignored in that cycle.
REQ-014 SHALL make at most one state decision per edge. A completed write and a new acceptance on the same edge SHALL both take effect, and the new word's address is the incremented address.
REQ-015 SHALL keep mem_wr_data at 0 when mem_wr_en=0.

Reset
REQ-016 While reset_n=0, SHALL force immediately (asynchronously):
  mem_wr_en=0, mem_wr_data=0, mem_addr=0, words_written=0, full=0, err=0;
  in_ready=0 while reset_n=0, and in_ready=1 from the first edge after reset_n rises.
REQ-017 Reset asserted during a pending write SHALL abort that write with no memory update.

Verification
REQ-018 ADD rd=1 rn=2 rm=3 after reset -> next cycle mem_wr_en=1, mem_addr=0, mem_wr_data=0x8B030041.
REQ-019 ADDI rd=5 rn=5 imm=10, then CBNZ rd=9 imm=-2, back-to-back with mem_wr_ready=1 -> 0x910028A5 at address 0, then 0xB5FFFFC9 at address 1 in consecutive cycles.
REQ-020 LDUR rd=1 rn=2 imm=256 -> handshake completes, no mem_wr_en, err=1, mem_addr unchanged. Then STUR rd=1 rn=2 imm=-1 -> 0xF81FF041 written.
REQ-021 mem_wr_ready held 0 for 3 cycles during a pending write -> mem_wr_en, mem_addr and mem_wr_data stable, in_ready=0; write completes on the 4th edge.
REQ-022 DEPTH_LOG2=2, 4 writes -> full=1, in_ready=0, words_written=4, a 5th request is not accepted. Then clear -> full=0, mem_addr=0, err=0, in_ready=1.
REQ-023 reset_n pulsed low while mem_wr_en=1 -> outputs zero immediately, no write completes, next accepted word is written to address 0.
